sram_1rw1r_param: RTL and testbench
===================================

# sram_1rw1r_param

Parametrised, single-clock, one read/write plus one read-only SRAM model for the pedal datapath's delay and effect buffers. It generalises the existing OpenRAM-style model with a configurable data width, depth and byte write mask, and a selectable read latency. It adds per-port read-valid strobes, defined write-to-read collision forwarding, and an optional post-reset clear sweep. It sits between the effect engines (delay/echo/reverb line controllers) and the sample memory.

## Interface
- `DATA_WIDTH`, 16: word width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 14: address width in bits; `RAM_DEPTH` = 1 << `ADDR_WIDTH`.
- `NUM_WMASKS`, `DATA_WIDTH`/8: byte-lane count. This value is derived, not overridden.
- `READ_LATENCY`, 1: legal values are 1 or 2. Any other value is an elaboration error.
---
- `clk`  in  1  single clock for both ports.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ready`  out  1  memory accepts requests.
- `csb0`  in  1  port 0 chip select, active low.
- `web0`  in  1  port 0 write enable, active low.
- `wmask0`  in  `NUM_WMASKS`  byte write enables, active high.
- `addr0`  in  `ADDR_WIDTH`  port 0 address.
- `din0`  in  `DATA_WIDTH`  port 0 write data.
- `dout0`  out  `DATA_WIDTH`  port 0 read data.
- `dout0_valid`  out  1  one-cycle strobe marking a new `dout0`.
- `csb1`  in  1  port 1 chip select, active low (read-only port).
- `addr1`  in  `ADDR_WIDTH`  port 1 address.
- `dout1`  out  `DATA_WIDTH`  port 1 read data.
- `dout1_valid`  out  1  one-cycle strobe marking a new `dout1`.

## Operation
- **Request acceptance.** A request is accepted at a `clk` rising edge only when `ready`=1 and the port's chip select is low. Requests made while `ready`=0 are dropped: no write, no valid strobe.
- **Port 0 write** (`csb0`=0, `web0`=0): lane i, bits [8i+7:8i], is written only when `wmask0[i]`=1. A write produces no `dout0_valid`.
- **Port 0 read** (`csb0`=0, `web0`=1): returns `mem[addr0]`.
- **Port 1 read** (`csb1`=0): returns `mem[addr1]`.
- **Collision.** A port 0 write and a port 1 read to the same address in the same cycle return write-first data on `dout1`: masked lanes carry `din0`, unmasked lanes carry the old contents. No X is produced.
- **Output hold.** `dout0` and `dout1` hold their last read value until the next accepted read. They never go X after reset.
- **Clear FSM states** (when `SRAM_CLEAR_ON_RESET_EN` is compiled in):
  - `CLEAR`: zeros are written to `clr_addr`, which increments each cycle.
  - `READY`: normal operation.
  - Transition `CLEAR`→`READY` occurs after the write to `RAM_DEPTH`-1.
  - `READY` is terminal until reset.
- **Reset mid-operation.** Asserting `rst_n` at any time aborts in-flight reads: the valid pipeline is cleared and no strobe emerges. If the clear feature is enabled, the sweep restarts at address 0.

## Timing
- **Reset values:**
  - `ready`=0.
  - `dout0`=`dout1`=0.
  - `dout0_valid`=`dout1_valid`=0.
  - Clear FSM in `CLEAR`, with `clr_addr`=0.
- **Sampling.** Inputs are sampled at rising edge N. A write is committed at edge N, so a read sampled at edge N+1 sees the new data.
- **`READ_LATENCY`=1:** `dout`/`valid` update at edge N and are visible to logic sampling at edge N+1.
- **`READ_LATENCY`=2:** one extra output register is added, so the update happens at edge N+1.
- **Back-to-back reads:** one read per port per cycle. `valid` stays high over consecutive accepted reads.
- **Address wrap.** Addresses are exactly `ADDR_WIDTH` bits, so no out-of-range access is possible. Callers implement circular buffers by letting the address counter wrap.

## Configuration
- **`SRAM_CLEAR_ON_RESET_EN` defined:**
  - After `rst_n` deasserts, the clear FSM zeroes all `RAM_DEPTH` words, one per cycle.
  - `ready` rises at the `RAM_DEPTH`-th rising edge after reset release. For the default depth this is 16384 cycles.
- **Not defined:**
  - No clear FSM is built.
  - `ready` rises at the first rising edge after reset release.
  - Memory contents are X until written.

## Structure
- **Shared package `sram_pkg`:**
  - clear-FSM state enum (`CLEAR`, `READY`);
  - `READ_LATENCY` legality check constant;
  - the lane width constant 8.
- **Sub-module `sram_clear_seq`:** clear FSM plus address counter. It outputs `ready`, `clr_we`, `clr_addr`. It is instantiated only under `SRAM_CLEAR_ON_RESET_EN`.
- **Top level:** memory array, write-mask merge, collision forward and latency pipeline.

## Test plan
- **Masked write, then read.** Write 0xBEEF to address 0x0010 with mask 2'b11, then write 0x1200 with mask 2'b10, then read on port 0 → `dout0`=0x12EF, with `dout0_valid` high for one cycle at the configured latency.
- **Collision.** Same-cycle port 0 write of 0xA5A5 (mask 2'b01) and port 1 read of the same address, which previously held 0x0F0F → `dout1`=0x0FA5.
- **Dual-port streaming.** Read addresses 0..7 on both ports on consecutive cycles, with `READ_LATENCY`=1 and then `READ_LATENCY`=2 → `valid` high for 8 consecutive cycles, data in order, first strobe delayed by exactly the configured latency.
- **Clear feature.** With `SRAM_CLEAR_ON_RESET_EN` and `ADDR_WIDTH`=4: request during `ready`=0 → ignored. `ready` rises at the 16th edge after reset release. Reads of 0..15 → all 0.
- **Reset mid-clear and mid-read.** Assert `rst_n`=0 at sweep address 7, release → sweep restarts at 0 and `ready` is delayed by a full 16 cycles. Assert reset with a read in flight → no `valid` strobe, `dout`=0.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the parametrised 1RW+1R sample memory and its clear sequencer.
package sram_pkg;

   localparam int LANE_WIDTH       = 8;
   localparam int MIN_READ_LATENCY = 1;
   localparam int MAX_READ_LATENCY = 2;

   typedef enum logic {
      CLEAR = 1'b0,
      READY = 1'b1
   } clr_state_t;

   function automatic bit read_latency_ok(input int lat);
      return (lat >= MIN_READ_LATENCY) && (lat <= MAX_READ_LATENCY);
   endfunction

endpackage

// File: rtl/sram_clear_seq.sv
// Post-reset clear sweep: writes zero to every word, one per cycle, then raises ready.
//
// state | meaning
// ------+-----------------------------------------------
// CLEAR | zeroing mem[clr_addr], clr_addr advances each cycle
// READY | sweep finished, memory accepts requests until reset
module sram_clear_seq
   import sram_pkg::*;
#(
   parameter int ADDR_WIDTH = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  ready,
   output logic                  clr_we,
   output logic [ADDR_WIDTH-1:0] clr_addr
);

   clr_state_t state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= CLEAR;
         clr_addr <= '0;
         clr_we   <= 1'b1;
         ready    <= 1'b0;
      end else begin
         case (state)
            CLEAR: begin
               // Terminal count is the last word; the write to it happens on this edge.
               if (clr_addr == '1) begin
                  state  <= READY;
                  clr_we <= 1'b0;
                  ready  <= 1'b1;
               end else begin
                  clr_addr <= clr_addr + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: rtl/sram_1rw1r_param.sv
// One read/write plus one read-only port sample memory with byte masks and 1- or 2-cycle read latency.
// Define SRAM_CLEAR_ON_RESET_EN to zero the array after every reset before ready rises.
module sram_1rw1r_param
   import sram_pkg::*;
#(
   parameter  int DATA_WIDTH   = 16,
   parameter  int ADDR_WIDTH   = 14,
   parameter  int READ_LATENCY = 1,
   localparam int NUM_WMASKS   = DATA_WIDTH / LANE_WIDTH,
   localparam int RAM_DEPTH    = 1 << ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  ready,
   input  logic                  csb0,
   input  logic                  web0,
   input  logic [NUM_WMASKS-1:0] wmask0,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [DATA_WIDTH-1:0] din0,
   output logic [DATA_WIDTH-1:0] dout0,
   output logic                  dout0_valid,
   input  logic                  csb1,
   input  logic [ADDR_WIDTH-1:0] addr1,
   output logic [DATA_WIDTH-1:0] dout1,
   output logic                  dout1_valid
);

   if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
      $error("sram_1rw1r_param: READ_LATENCY must be 1 or 2");
   end
   if ((DATA_WIDTH % LANE_WIDTH) != 0) begin : g_bad_width
      $error("sram_1rw1r_param: DATA_WIDTH must be a multiple of 8");
   end

   logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

   logic                  rd0;
   logic                  rd1;
   logic                  wr0;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [NUM_WMASKS-1:0] mem_wmask;
   logic [DATA_WIDTH-1:0] rd1_word;

   assign wr0 = ready & ~csb0 & ~web0;
   assign rd0 = ready & ~csb0 & web0;
   assign rd1 = ready & ~csb1;

`ifdef SRAM_CLEAR_ON_RESET_EN
   logic                  clr_we;
   logic [ADDR_WIDTH-1:0] clr_addr;

   sram_clear_seq #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_clear_seq (
      .clk      (clk),
      .rst_n    (rst_n),
      .ready    (ready),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   // The sweep owns the write port until ready; port 0 cannot be accepted meanwhile.
   always_comb begin
      mem_we    = clr_we | wr0;
      mem_waddr = clr_we ? clr_addr : addr0;
      mem_wdata = clr_we ? '0 : din0;
      mem_wmask = clr_we ? '1 : wmask0;
   end
`else
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready <= 1'b0;
      end else begin
         ready <= 1'b1;
      end
   end

   always_comb begin
      mem_we    = wr0;
      mem_waddr = addr0;
      mem_wdata = din0;
      mem_wmask = wmask0;
   end
`endif

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < NUM_WMASKS; i++) begin
            if (mem_wmask[i]) begin
               mem[mem_waddr][i*LANE_WIDTH +: LANE_WIDTH] <= mem_wdata[i*LANE_WIDTH +: LANE_WIDTH];
            end
         end
      end
   end

   // Write-first forwarding: a same-address port 0 write is merged into the port 1 result.
   always_comb begin
      rd1_word = mem[addr1];
      if (wr0 && (addr0 == addr1)) begin
         for (int i = 0; i < NUM_WMASKS; i++) begin
            if (wmask0[i]) begin
               rd1_word[i*LANE_WIDTH +: LANE_WIDTH] = din0[i*LANE_WIDTH +: LANE_WIDTH];
            end
         end
      end
   end

   logic [DATA_WIDTH-1:0] q0_data;
   logic [DATA_WIDTH-1:0] q1_data;
   logic                  q0_valid;
   logic                  q1_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q0_data  <= '0;
         q1_data  <= '0;
         q0_valid <= 1'b0;
         q1_valid <= 1'b0;
      end else begin
         q0_valid <= rd0;
         q1_valid <= rd1;
         if (rd0) begin
            q0_data <= mem[addr0];
         end
         if (rd1) begin
            q1_data <= rd1_word;
         end
      end
   end

   if (READ_LATENCY == 2) begin : g_lat2
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            dout0       <= '0;
            dout1       <= '0;
            dout0_valid <= 1'b0;
            dout1_valid <= 1'b0;
         end else begin
            dout0_valid <= q0_valid;
            dout1_valid <= q1_valid;
            if (q0_valid) begin
               dout0 <= q0_data;
            end
            if (q1_valid) begin
               dout1 <= q1_data;
            end
         end
      end
   end else begin : g_lat1
      assign dout0       = q0_data;
      assign dout1       = q1_data;
      assign dout0_valid = q0_valid;
      assign dout1_valid = q1_valid;
   end

endmodule

// File: tb/tb_sram_1rw1r_param.sv
// Scoreboard bench for sram_1rw1r_param: latency-1 and latency-2 instances driven in lockstep.
`timescale 1ns/1ps
module tb_sram_1rw1r_param;
   import sram_pkg::*;

   localparam int DW    = 16;
   localparam int AW    = 5;
   localparam int DEPTH = 1 << AW;
`ifdef SRAM_CLEAR_ON_RESET_EN
   localparam int READY_EDGES = DEPTH;
`else
   localparam int READY_EDGES = 1;
`endif

   logic          clk    = 1'b0;
   logic          rst_n  = 1'b1;
   logic          csb0   = 1'b1;
   logic          web0   = 1'b1;
   logic [1:0]    wmask0 = '0;
   logic [AW-1:0] addr0  = '0;
   logic [DW-1:0] din0   = '0;
   logic          csb1   = 1'b1;
   logic [AW-1:0] addr1  = '0;

   logic          ready_a, ready_b;
   logic [DW-1:0] d0a, d1a, d0b, d1b;
   logic          v0a, v1a, v0b, v1b;

   sram_1rw1r_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .ready(ready_a),
      .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
      .dout0(d0a), .dout0_valid(v0a),
      .csb1(csb1), .addr1(addr1), .dout1(d1a), .dout1_valid(v1a)
   );

   sram_1rw1r_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .ready(ready_b),
      .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
      .dout0(d0b), .dout0_valid(v0b),
      .csb1(csb1), .addr1(addr1), .dout1(d1b), .dout1_valid(v1b)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int            cyc;
      logic [DW-1:0] data;
   } exp_t;

   // Queue ids: 0 = A port0, 1 = A port1, 2 = B port0, 3 = B port1
   exp_t q_0[$];
   exp_t q_1[$];
   exp_t q_2[$];
   exp_t q_3[$];

   logic [DW-1:0] model [DEPTH];
   logic [DW-1:0] last  [4];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic check_int(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   function automatic int q_size(input int id);
      case (id)
         0:       return q_0.size();
         1:       return q_1.size();
         2:       return q_2.size();
         default: return q_3.size();
      endcase
   endfunction

   function automatic int q_front_cyc(input int id);
      case (id)
         0:       return q_0[0].cyc;
         1:       return q_1[0].cyc;
         2:       return q_2[0].cyc;
         default: return q_3[0].cyc;
      endcase
   endfunction

   task automatic q_pop(input int id, output exp_t e);
      case (id)
         0:       e = q_0.pop_front();
         1:       e = q_1.pop_front();
         2:       e = q_2.pop_front();
         default: e = q_3.pop_front();
      endcase
   endtask

   task automatic q_push(input int id, input int c, input logic [DW-1:0] d);
      exp_t e;
      e.cyc  = c;
      e.data = d;
      case (id)
         0:       q_0.push_back(e);
         1:       q_1.push_back(e);
         2:       q_2.push_back(e);
         default: q_3.push_back(e);
      endcase
   endtask

   task automatic mon(input int id, input logic v, input logic [DW-1:0] d);
      exp_t e;
      while (q_size(id) > 0 && q_front_cyc(id) < cyc) begin
         q_pop(id, e);
         total++;
         bad++;
         $display("FAIL missing_strobe_p%0d: no valid seen, required one at cycle %0d", id, e.cyc);
      end
      if (!rst_n) last[id] = '0;
      if (v === 1'b1) begin
         if (q_size(id) == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_strobe_p%0d: valid=1 at cycle %0d, required 0", id, cyc);
         end else begin
            q_pop(id, e);
            check_int($sformatf("strobe_cycle_p%0d", id), cyc, e.cyc);
            check($sformatf("rdata_p%0d", id), d, e.data);
            last[id] = d;
         end
      end else begin
         check($sformatf("hold_p%0d", id), d, last[id]);
      end
   endtask

   always @(negedge clk) begin
      mon(0, v0a, d0a);
      mon(1, v1a, d1a);
      mon(2, v0b, d0b);
      mon(3, v1b, d1b);
   end

   // Reference behaviour: commit the write first, then every read sees the updated array.
   task automatic apply(input logic c0, input logic w0, input logic [1:0] m, input logic [AW-1:0] a0,
                        input logic [DW-1:0] d, input logic c1, input logic [AW-1:0] a1);
      if (!c0 && !w0) begin
         for (int i = 0; i < 2; i++)
            if (m[i]) model[a0][i*8 +: 8] = d[i*8 +: 8];
      end
      if (!c0 && w0) begin
         q_push(0, cyc + 1, model[a0]);
         q_push(2, cyc + 2, model[a0]);
      end
      if (!c1) begin
         q_push(1, cyc + 1, model[a1]);
         q_push(3, cyc + 2, model[a1]);
      end
   endtask

   task automatic step(input bit track, input logic c0, input logic w0, input logic [1:0] m,
                       input logic [AW-1:0] a0, input logic [DW-1:0] d, input logic c1,
                       input logic [AW-1:0] a1);
      @(negedge clk);
      csb0 = c0; web0 = w0; wmask0 = m; addr0 = a0; din0 = d; csb1 = c1; addr1 = a1;
      if (track) apply(c0, w0, m, a0, d, c1, a1);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b1, 1'b1, 2'b00, '0, '0, 1'b1, '0);
   endtask

   task automatic do_reset(input bit mid_clear);
      int n;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      csb0 = 1'b1; csb1 = 1'b1;
      @(negedge clk);
      check_int("reset_ready_a", ready_a, 0);
      check_int("reset_ready_b", ready_b, 0);
      check("reset_dout0_a", d0a, '0);
      check("reset_dout1_b", d1b, '0);
      check_int("reset_valid_a", {v0a, v1a}, 0);
      check_int("reset_valid_b", {v0b, v1b}, 0);
      @(negedge clk);
      if (mid_clear) begin
         rst_n = 1'b1;
         repeat (8) @(negedge clk);
         check_int("ready_mid_sweep", ready_a, 0);
         @(posedge clk);
         #1;
         rst_n = 1'b0;
         @(negedge clk);
      end
      rst_n  = 1'b1;
      // Request sampled on the first edge after release, while ready is still low: must vanish.
      csb0 = 1'b0; web0 = 1'b0; wmask0 = 2'b11; addr0 = AW'(3); din0 = 16'hDEAD;
      csb1 = 1'b0; addr1 = AW'(3);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         csb0 = 1'b1; csb1 = 1'b1;
      end while (ready_a !== 1'b1 && n < 5000);
      check_int("ready_edges_a", n, READY_EDGES);
      check_int("ready_b", ready_b, 1);
`ifdef SRAM_CLEAR_ON_RESET_EN
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
`endif
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      logic [AW-1:0] ra, rb;
      #2;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      do_reset(1'b0);

`ifdef SRAM_CLEAR_ON_RESET_EN
      for (int i = 0; i < DEPTH; i++)
         step(1'b1, 1'b0, 1'b1, 2'b00, AW'(i), '0, 1'b0, AW'(DEPTH - 1 - i));
      idle(4);
      do_reset(1'b1);
`endif

      for (int i = 0; i < DEPTH; i++)
         step(1'b1, 1'b0, 1'b0, 2'b11, AW'(i), DW'($urandom), 1'b1, '0);

      // Read in flight when reset hits: no strobe may emerge.
      idle(4);
      step(1'b0, 1'b0, 1'b1, 2'b00, AW'(5), '0, 1'b0, AW'(6));
      do_reset(1'b0);
`ifndef SRAM_CLEAR_ON_RESET_EN
      idle(1);
`endif
      step(1'b1, 1'b0, 1'b1, 2'b00, AW'(3), '0, 1'b0, AW'(3));

      step(1'b1, 1'b0, 1'b0, 2'b11, AW'(16), 16'hBEEF, 1'b1, '0);
      step(1'b1, 1'b0, 1'b0, 2'b10, AW'(16), 16'h1200, 1'b1, '0);
      step(1'b1, 1'b0, 1'b1, 2'b00, AW'(16), '0, 1'b1, '0);

      step(1'b1, 1'b0, 1'b0, 2'b11, AW'(5), 16'h0F0F, 1'b1, '0);
      step(1'b1, 1'b0, 1'b0, 2'b01, AW'(5), 16'hA5A5, 1'b0, AW'(5));
      step(1'b1, 1'b0, 1'b1, 2'b00, AW'(5), '0, 1'b0, AW'(5));
      idle(3);

      for (int i = 0; i < 8; i++)
         step(1'b1, 1'b0, 1'b1, 2'b00, AW'(i), '0, 1'b0, AW'(i));
      idle(3);

      for (int k = 0; k < 300; k++) begin
         ra = AW'($urandom_range(0, DEPTH - 1));
         rb = ($urandom_range(0, 1) == 1) ? ra : AW'($urandom_range(0, DEPTH - 1));
         step(1'b1, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
              2'($urandom_range(0, 3)), ra, DW'($urandom), ($urandom_range(0, 3) == 0), rb);
      end
      idle(6);

      check_int("drain_q0", q_0.size(), 0);
      check_int("drain_q1", q_1.size(), 0);
      check_int("drain_q2", q_2.size(), 0);
      check_int("drain_q3", q_3.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
